memory_stage: RTL and testbench

- Consumer side of the execute stage outputs: MEM/WB pipeline stage of the MIPS core.
- Registers execute results and the 8-bit control bundle, and performs loads/stores on the data memory over a req/ready handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Drives register-file write-back (data, destination, enable).

---
 rtl/memory_stage_if.sv | 36 +++
 rtl/memory_stage.sv | 180 ++++++++++++++++++
 tb/tb_memory_stage.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// ----------------------------------------------------------------------------
// memory_stage_if
// Data-memory request/response bus between the MEM/WB stage and data memory.
//
// Signals:
//   mem_req_out    request strobe, held until mem_ready_in
//   mem_we_out     1 = write, 0 = read
//   mem_addr_out   word-aligned byte address (low 2 bits zero)
//   mem_be_out     byte enables, one per 8-bit lane
//   mem_wdata_out  write data, replicated across the enabled lanes
//   mem_rdata_in   read data, valid together with mem_ready_in
//   mem_ready_in   access complete
//
// Modports: master = memory stage side, slave = memory side.
// ----------------------------------------------------------------------------
interface memory_stage_if #(
  parameter int MEM_AW = 32
);
  logic              mem_req_out;
  logic              mem_we_out;
  logic [MEM_AW-1:0] mem_addr_out;
  logic [3:0]        mem_be_out;
  logic [31:0]       mem_wdata_out;
  logic [31:0]       mem_rdata_in;
  logic              mem_ready_in;

  modport master (
    output mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out,
    input  mem_rdata_in, mem_ready_in
  );

  modport slave (
    input  mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out,
    output mem_rdata_in, mem_ready_in
  );
endinterface

// File: rtl/memory_stage.sv
// ----------------------------------------------------------------------------
// memory_stage
// MEM/WB pipeline stage of the MIPS core. Registers the execute-stage results
// and 8-bit control bundle, performs loads/stores on the data memory over a
// req/ready handshake, stalls upstream while an access is outstanding, and
// drives register-file write-back.
//
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   bundle_in            control bundle {link, unsigned, size[1:0],
//                        mem_write, mem_read, mem_to_reg, reg_write}
//   pc_seq_in            PC+4 (link value)
//   alu_in               ALU result / effective address
//   reg_read2_in         store data
//   reg_write_dest_in    destination register
//   stall_out            hold upstream stages
//   mem                  data-memory bus (memory_stage_if.master)
//   wb_en_out/dest/data  register-file write-back
//   fault_out            misaligned access trap
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no request, one-cycle fault_out). Without it fault_out is 0 and
// the offending low address bits are simply ignored.
// ----------------------------------------------------------------------------
module memory_stage #(
  parameter int MEM_AW = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            bundle_in,
  input  logic [31:0]           pc_seq_in,
  input  logic [31:0]           alu_in,
  input  logic [31:0]           reg_read2_in,
  input  logic [4:0]            reg_write_dest_in,
  output logic                  stall_out,
  memory_stage_if.master        mem,
  output logic                  wb_en_out,
  output logic [4:0]            wb_dest_out,
  output logic [31:0]           wb_data_out,
  output logic                  fault_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [7:0]  bundle_reg;
  logic [31:0] pc_seq_reg;
  logic [31:0] alu_reg;
  logic [31:0] rd2_reg;
  logic [4:0]  dest_reg;
  logic [31:0] load_q_reg;

  // Bundle decode
  logic       reg_write, mem_to_reg, mem_read, mem_write, is_unsigned, link;
  logic [1:0] size;
  logic       mem_op, size_byte, size_half;
  logic       misaligned, mem_req;

  assign reg_write   = bundle_reg[0];
  assign mem_to_reg  = bundle_reg[1];
  assign mem_read    = bundle_reg[2];
  assign mem_write   = bundle_reg[3];
  assign size        = bundle_reg[5:4];
  assign is_unsigned = bundle_reg[6];
  assign link        = bundle_reg[7];

  assign mem_op    = mem_read | mem_write;
  assign size_byte = (size == 2'b00);
  assign size_half = (size == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
  // Size 11 decodes as word, so any size other than byte/half needs alu[1:0]=0.
  assign misaligned = mem_op &
                      ((size_half & alu_reg[0]) |
                       (!size_byte && !size_half && (alu_reg[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // A request can only reach BUSY when it was aligned, so the misaligned
  // term only matters in IDLE.
  assign mem_req   = mem_op && !misaligned &&
                     ((state_reg == ST_IDLE) || (state_reg == ST_BUSY));
  assign stall_out = mem_req;
  assign fault_out = (state_reg == ST_IDLE) && misaligned;

  // Request fields come straight from the held stage registers, so they stay
  // stable for the whole request. They read zero when idle.
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw;

  always_comb begin
    be_raw    = 4'hF;
    wdata_raw = rd2_reg;
    if (size_byte) begin
      be_raw    = 4'b0001 << alu_reg[1:0];
      wdata_raw = {4{rd2_reg[7:0]}};
    end else if (size_half) begin
      be_raw    = alu_reg[1] ? 4'b1100 : 4'b0011;
      wdata_raw = {2{rd2_reg[15:0]}};
    end
  end

  assign mem.mem_req_out   = mem_req;
  assign mem.mem_we_out    = mem_req & mem_write;
  assign mem.mem_addr_out  = mem_req ? {alu_reg[MEM_AW-1:2], 2'b00} : '0;
  assign mem.mem_be_out    = mem_req ? be_raw : 4'h0;
  assign mem.mem_wdata_out = mem_req ? wdata_raw : 32'h0;

  // FSM
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (mem_req) state_next = mem.mem_ready_in ? ST_DONE : ST_BUSY;
      ST_BUSY: if (mem.mem_ready_in) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      bundle_reg <= 8'h00;
      pc_seq_reg <= '0;
      alu_reg    <= '0;
      rd2_reg    <= '0;
      dest_reg   <= '0;
      load_q_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (!stall_out) begin
        bundle_reg <= bundle_in;
        pc_seq_reg <= pc_seq_in;
        alu_reg    <= alu_in;
        rd2_reg    <= reg_read2_in;
        dest_reg   <= reg_write_dest_in;
      end
      // ready outside an active request is ignored
      if (mem_req && mem.mem_ready_in) load_q_reg <= mem.mem_rdata_in;
    end
  end

  // Load lane selection and extension
  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = load_q_reg[8*gi +: 8];
  end

  assign byte_sel = lane[alu_reg[1:0]];
  assign half_sel = alu_reg[1] ? load_q_reg[31:16] : load_q_reg[15:0];

  always_comb begin
    load_ext = load_q_reg;
    if (size_byte)
      load_ext = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    else if (size_half)
      load_ext = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
  end

  // Write-back
  logic wb_valid;
  assign wb_valid = ((state_reg == ST_IDLE) && !mem_op) || (state_reg == ST_DONE);

  always_comb begin
    wb_data_out = alu_reg;
    if (link)            wb_data_out = pc_seq_reg;
    else if (mem_to_reg) wb_data_out = load_ext;
  end

  assign wb_en_out   = reg_write && (dest_reg != 5'd0) && wb_valid;
  assign wb_dest_out = dest_reg;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  localparam int MEM_AW = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  bundle_in;
  logic [31:0] pc_seq_in, alu_in, reg_read2_in;
  logic [4:0]  reg_write_dest_in;
  logic        stall_out, wb_en_out, fault_out;
  logic [4:0]  wb_dest_out;
  logic [31:0] wb_data_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_wb, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_en, obs_fault, obs_req;

  memory_stage_if #(.MEM_AW(MEM_AW)) mif ();

  memory_stage #(.MEM_AW(MEM_AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .bundle_in         (bundle_in),
    .pc_seq_in         (pc_seq_in),
    .alu_in            (alu_in),
    .reg_read2_in      (reg_read2_in),
    .reg_write_dest_in (reg_write_dest_in),
    .stall_out         (stall_out),
    .mem               (mif),
    .wb_en_out         (wb_en_out),
    .wb_dest_out       (wb_dest_out),
    .wb_data_out       (wb_data_out),
    .fault_out         (fault_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_be(input logic [7:0] b, input logic [31:0] a);
    case (b[5:4])
      2'b00:   return 4'(1 << a[1:0]);
      2'b01:   return a[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] b, input logic [31:0] rd2);
    case (b[5:4])
      2'b00:   return {24'h0, rd2[7:0]} * 32'h01010101;
      2'b01:   return {16'h0, rd2[15:0]} * 32'h00010001;
      default: return rd2;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] b, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    case (b[5:4])
      2'b00: begin
        v = (rd >> (8 * a[1:0])) & 32'hFF;
        if (!b[6] && v >= 128) v = v - 256;
      end
      2'b01: begin
        v = (rd >> (16 * a[1])) & 32'hFFFF;
        if (!b[6] && v >= 32768) v = v - 65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic m_misaligned(input logic [7:0] b, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (b[2] | b[3]) && (((b[5:4] == 2'b01) && a[0]) || (b[5] && (a[1:0] != 2'b00)));
`else
    return 1'b0;
`endif
  endfunction

  // Issue one instruction from IDLE, run its handshake (ready after `delay`
  // request cycles) and check everything up to write-back.
  task automatic run_instr(input logic [7:0] b, input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] rd2, input logic [4:0] dest,
                           input int delay, input logic [31:0] rdata);
    logic        mem_op, exp_en;
    logic [31:0] exp_wb;
    mem_op = b[2] | b[3];
    exp_en = b[0] && (dest != 5'd0);
    exp_wb = b[7] ? pc : (b[1] ? m_load(b, a, rdata) : a);
    chk("pre_stall", stall_out, 0);
    bundle_in = b; pc_seq_in = pc; alu_in = a; reg_read2_in = rd2; reg_write_dest_in = dest;
    tick();
    bundle_in = 8'h00; pc_seq_in = $urandom; alu_in = $urandom;
    reg_read2_in = $urandom; reg_write_dest_in = 5'($urandom);
    obs_fault = fault_out;
    obs_req   = mif.mem_req_out;
    if (mem_op && m_misaligned(b, a)) begin
      chk("trap_fault", fault_out, 1);
      chk("trap_req", mif.mem_req_out, 0);
      chk("trap_stall", stall_out, 0);
      chk("trap_wb_en", wb_en_out, 0);
      tick();
      chk("trap_fault_clr", fault_out, 0);
      return;
    end
    chk("fault", fault_out, 0);
    if (mem_op) begin
      for (int c = 0; c <= delay; c++) begin
        chk("req", mif.mem_req_out, 1);
        chk("stall", stall_out, 1);
        chk("we", mif.mem_we_out, b[3]);
        chk("addr", mif.mem_addr_out, {a[31:2], 2'b00});
        chk("be", mif.mem_be_out, m_be(b, a));
        if (b[3]) chk("wdata", mif.mem_wdata_out, m_wdata(b, rd2));
        chk("busy_wb_en", wb_en_out, 0);
        if (c == 0) begin
          obs_be = mif.mem_be_out;
          obs_wdata = mif.mem_wdata_out;
        end
        mif.mem_ready_in = (c == delay);
        mif.mem_rdata_in = (c == delay) ? rdata : $urandom;
        tick();
      end
      mif.mem_ready_in = 1'b0;
      mif.mem_rdata_in = $urandom;
      chk("done_req", mif.mem_req_out, 0);
      chk("done_stall", stall_out, 0);
    end else begin
      chk("alu_req", mif.mem_req_out, 0);
      chk("alu_stall", stall_out, 0);
    end
    chk("wb_en", wb_en_out, exp_en);
    chk("wb_dest", wb_dest_out, dest);
    if (exp_en) chk("wb_data", wb_data_out, exp_wb);
    obs_wb = wb_data_out;
    obs_en = wb_en_out;
    tick();
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] a, rd2, rdata;
    logic [4:0]  dest;
    int          kind, delay;

    // Reset with garbage on every input
    reset = 1'b0;
    bundle_in = 8'hFF; pc_seq_in = $urandom; alu_in = $urandom;
    reg_read2_in = $urandom; reg_write_dest_in = 5'h1F;
    mif.mem_ready_in = 1'b1; mif.mem_rdata_in = $urandom;
    tick(); tick();
    chk("rst_stall", stall_out, 0);
    chk("rst_req", mif.mem_req_out, 0);
    chk("rst_we", mif.mem_we_out, 0);
    chk("rst_addr", mif.mem_addr_out, 0);
    chk("rst_be", mif.mem_be_out, 0);
    chk("rst_wdata", mif.mem_wdata_out, 0);
    chk("rst_wb_en", wb_en_out, 0);
    chk("rst_wb_dest", wb_dest_out, 0);
    chk("rst_wb_data", wb_data_out, 0);
    chk("rst_fault", fault_out, 0);
    mif.mem_ready_in = 1'b0;
    bundle_in = 8'h00;
    reset = 1'b1;
    tick();

    // ALU op
    run_instr(8'h01, 32'h0, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
    chk("alu_wb_data", obs_wb, 32'h1234);
    chk("alu_wb_en", obs_en, 1);

    // lw, ready after three wait cycles (four stall cycles)
    run_instr(8'h27, 32'h0, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF);
    chk("lw_wb_data", obs_wb, 32'hDEADBEEF);
    chk("lw_be", obs_be, 4'hF);

    // lb / lbu from lane 3
    run_instr(8'h07, 32'h0, 32'h103, 32'h0, 5'd8, 1, 32'h80123456);
    chk("lb_wb_data", obs_wb, 32'hFFFFFF80);
    run_instr(8'h47, 32'h0, 32'h103, 32'h0, 5'd8, 0, 32'h80123456);
    chk("lbu_wb_data", obs_wb, 32'h00000080);

    // sh to upper half
    run_instr(8'h18, 32'h0, 32'h202, 32'h0000ABCD, 5'd0, 2, 32'h0);
    chk("sh_be", obs_be, 4'b1100);
    chk("sh_wdata", obs_wdata, 32'hABCDABCD);
    chk("sh_wb_en", obs_en, 0);

    // jal link, then the same to r0
    run_instr(8'h81, 32'h40, 32'h999, 32'h0, 5'd31, 0, 32'h0);
    chk("jal_wb_data", obs_wb, 32'h40);
    run_instr(8'h81, 32'h40, 32'h999, 32'h0, 5'd0, 0, 32'h0);
    chk("jal_r0_wb_en", obs_en, 0);

    // lw at a misaligned address
    run_instr(8'h27, 32'h0, 32'h102, 32'h0, 5'd9, 1, 32'h11223344);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_fault", obs_fault, 1);
    chk("mis_req", obs_req, 0);
`else
    chk("mis_fault", obs_fault, 0);
    chk("mis_be", obs_be, 4'hF);
    chk("mis_wb_data", obs_wb, 32'h11223344);
`endif

    // Reset pulse during BUSY, then a late ready must be ignored
    bundle_in = 8'h27; alu_in = 32'h300; reg_write_dest_in = 5'd3;
    tick();
    bundle_in = 8'h00;
    chk("rb_req_idle", mif.mem_req_out, 1);
    tick();
    chk("rb_req_busy", mif.mem_req_out, 1);
    reset = 1'b0;
    tick();
    chk("rb_req_after", mif.mem_req_out, 0);
    chk("rb_stall_after", stall_out, 0);
    chk("rb_wb_en_after", wb_en_out, 0);
    reset = 1'b1;
    mif.mem_ready_in = 1'b1; mif.mem_rdata_in = 32'h55555555;
    chk("late_ready_req", mif.mem_req_out, 0);
    tick();
    mif.mem_ready_in = 1'b0;
    chk("late_ready_wb_en", wb_en_out, 0);
    chk("late_ready_stall", stall_out, 0);

    // Randomized instruction mix
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      b = 8'($urandom);
      case (kind)
        0:       b = b & 8'h71;             // ALU op
        1:       b = (b & 8'h70) | 8'h07;   // load
        2:       b = (b & 8'h34) | 8'h08;   // store (mem_read may also be set)
        default: b = (b & 8'h71) | 8'h80;   // link
      endcase
      a = $urandom; rd2 = $urandom; rdata = $urandom;
      dest = 5'($urandom);
      delay = $urandom_range(0, 3);
      run_instr(b, $urandom, a, rd2, dest, delay, rdata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
